// File: rtl/pxcnt_pkg.sv
// Shared types for the pxcnt family of counters: terminal behaviours and the
// one-shot sequencing states.
package pxcnt_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP     = 2'd0,
    CNT_SATURATE = 2'd1,
    CNT_ONESHOT  = 2'd2
  } cnt_mode_t;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/posedge_counter.sv
// Registered up/down counter with load, programmable upper limit, and
// wrap / saturate / one-shot terminal behaviour plus a terminal-count pulse.
module posedge_counter
  import pxcnt_pkg::*;
#(
  parameter int              NBITS = 8,
  parameter longint unsigned LIMIT = (64'd1 << NBITS) - 64'd1,
  parameter cnt_mode_t       MODE  = CNT_WRAP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [NBITS-1:0] LOAD_VAL,
  input  logic             DIR,
  output logic [NBITS-1:0] XOUT,
  output logic             TC,
  output logic             DONE
);

  localparam longint unsigned MAXV = (64'd1 << NBITS) - 64'd1;

  if (NBITS < 2 || NBITS > 32) begin : g_bad_nbits
    $error("posedge_counter: NBITS must be in 2..32");
  end
  if (LIMIT < 64'd1 || LIMIT > MAXV) begin : g_bad_limit
    $error("posedge_counter: LIMIT must be in 1..2**NBITS-1");
  end

  localparam logic [NBITS-1:0] LIM = LIMIT[NBITS-1:0];
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [NBITS-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  cnt_state_t       state_q, state_d;

  logic [NBITS-1:0] term, nxt, ld_val;
  logic             at_term, step_ok;

  assign term    = DIR ? '0 : LIM;
  assign at_term = (cnt_q == term);
  assign nxt     = DIR ? (cnt_q - ONE) : (cnt_q + ONE);
  assign ld_val  = (LOAD_VAL > LIM) ? LIM : LOAD_VAL;
  // One-shot only counts between a LOAD and reaching the terminal.
  assign step_ok = EN && ((MODE != CNT_ONESHOT) || (state_q == CNT_RUN));

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (LOAD) begin
      cnt_d   = ld_val;
      done_d  = 1'b0;
      state_d = (MODE == CNT_ONESHOT) ? CNT_RUN : CNT_IDLE;
    end else if (step_ok) begin
      if (!at_term) begin
        cnt_d = nxt;
        tc_d  = (nxt == term);
        if ((MODE == CNT_ONESHOT) && (nxt == term)) begin
          state_d = CNT_DONE;
          done_d  = 1'b1;
        end
      end else begin
        // Stepping while already at the terminal: no TC, since no step arrived there.
        case (MODE)
          CNT_WRAP:    cnt_d = DIR ? LIM : '0;
          CNT_ONESHOT: begin
            state_d = CNT_DONE;
            done_d  = 1'b1;
          end
          default:     cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= CNT_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign XOUT = cnt_q;
  assign TC   = tc_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_posedge_counter.sv
// Four counter configurations share one stimulus stream; a reference model
// predicts each cycle's outputs into a queue that a separate monitor drains.
module tb_posedge_counter;
  import pxcnt_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET = 1'b0, EN = 1'b0, LOAD = 1'b0, DIR = 1'b0;
  logic [7:0] LOAD_VAL = '0;

  logic [7:0] xa, xc;
  logic [3:0] xb, xd;
  logic [3:0] tc_o, dn_o;
  logic [3:0][7:0] xo;

  posedge_counter #(.NBITS(8), .MODE(CNT_WRAP)) u_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .DIR(DIR),
    .XOUT(xa), .TC(tc_o[0]), .DONE(dn_o[0]));
  posedge_counter #(.NBITS(4), .LIMIT(9), .MODE(CNT_WRAP)) u_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]), .DIR(DIR),
    .XOUT(xb), .TC(tc_o[1]), .DONE(dn_o[1]));
  posedge_counter #(.NBITS(8), .LIMIT(5), .MODE(CNT_SATURATE)) u_c (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .DIR(DIR),
    .XOUT(xc), .TC(tc_o[2]), .DONE(dn_o[2]));
  posedge_counter #(.NBITS(4), .LIMIT(3), .MODE(CNT_ONESHOT)) u_d (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]), .DIR(DIR),
    .XOUT(xd), .TC(tc_o[3]), .DONE(dn_o[3]));

  assign xo[0] = xa;
  assign xo[1] = {4'b0, xb};
  assign xo[2] = xc;
  assign xo[3] = {4'b0, xd};

  // Model parameters: width, limit, mode (0 wrap, 1 saturate, 2 one-shot).
  int NB[4]  = '{8, 4, 8, 4};
  int LIM[4] = '{255, 9, 5, 3};
  int MD[4]  = '{0, 0, 1, 2};
  int mx[4]  = '{0, 0, 0, 0};
  int mph[4] = '{0, 0, 0, 0};  // one-shot phase: 0 idle, 1 running, 2 finished

  typedef struct packed {
    logic [3:0][7:0] x;
    logic [3:0]      tc;
    logic [3:0]      dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [7:0] v, input logic d);
    exp_t ex;
    int   t, lv;
    bit   tc;
    @(negedge CLK);
    RESET = r; EN = e; LOAD = l; LOAD_VAL = v; DIR = d;
    for (int i = 0; i < 4; i++) begin
      tc = 1'b0;
      lv = int'(v) % (1 << NB[i]);
      if (r) begin
        mx[i] = 0; mph[i] = 0;
      end else if (l) begin
        mx[i]  = (lv > LIM[i]) ? LIM[i] : lv;
        mph[i] = (MD[i] == 2) ? 1 : 0;
      end else if (e && (MD[i] != 2 || mph[i] == 1)) begin
        t = d ? 0 : LIM[i];
        if (mx[i] != t) begin
          mx[i] = d ? mx[i] - 1 : mx[i] + 1;
          tc = (mx[i] == t);
          if (tc && MD[i] == 2) mph[i] = 2;
        end else if (MD[i] == 0) begin
          mx[i] = d ? LIM[i] : 0;
        end else if (MD[i] == 2) begin
          mph[i] = 2;
        end
      end
      ex.x[i]  = 8'(mx[i]);
      ex.tc[i] = tc;
      ex.dn[i] = (mph[i] == 2);
    end
    q.push_back(ex);
  endtask

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    exp_t ex;
    #1;
    if (q.size() > 0) begin
      ex = q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("xout", i, int'(xo[i]), int'(ex.x[i]));
        chk("tc",   i, int'(tc_o[i]), int'(ex.tc[i]));
        chk("done", i, int'(dn_o[i]), int'(ex.dn[i]));
      end
    end
  end

  initial begin
    logic d;
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 8'hFF, 0);
    // Free-running up count through a full 8-bit wrap; one-shot must stay at 0.
    for (int k = 0; k < 257; k++) drive(0, 1, 0, 0, 0);
    // Load 2 and count down through the lower terminal.
    drive(0, 0, 1, 8'd2, 1);
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, 1);
    // Clamped loads.
    drive(0, 0, 1, 8'd200, 0);
    drive(0, 1, 0, 0, 0);
    // One-shot run, hold, and restart.
    drive(0, 0, 1, 8'd0, 0);
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 8'd1, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0);
    // Reversal at the terminal, then saturating hold and re-arrival.
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 1);
    for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, 0);
    // Reset mid-count at 7 with EN and LOAD also high.
    drive(0, 0, 1, 8'd5, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 1, 8'd3, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0);
    // LOAD together with EN.
    drive(0, 1, 1, 8'd6, 0);
    drive(0, 1, 1, 8'd2, 1);
    // Randomized traffic.
    d = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) d = ~d;
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), 8'($urandom), d);
    end
    drive(0, 0, 0, 0, 0);
    @(posedge CLK);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
